writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameters SHALL be, one per line as name, default, meaning:
- DATA_W, 32, width of result, load data and CPSR values.
- REG_ADDR_W, 4, width of the register number.
- DEPTH, 4, number of pending-writeback queue entries; power of two, at least 2.
- CNT_W, 16, width of the retire counter.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- in_valid, in, 1, upstream presents an instruction.
- in_ready, out, 1, unit accepts an instruction this cycle.
- is_alu_op, in, 1, ALU result writeback.
- is_cmp_op, in, 1, CPSR writeback.
- is_ld_op, in, 1, load data writeback.
- rd_num_in, in, REG_ADDR_W, destination register.
- result, in, DATA_W, ALU result.
- cpsr_in, in, DATA_W, new CPSR value.
- dmem_val, in, DATA_W, load data.
- rf_ready, in, 1, register file accepts a write this cycle.
- rd_write_en, out, 1, register write strobe.
- rd_num, out, REG_ADDR_W, register write address.
- rd_val, out, DATA_W, register write data.
- cpsr_write_en, out, 1, CPSR write strobe.
- cpsr_out, out, DATA_W, CPSR write data.
- fwd_num, in, REG_ADDR_W, forwarding query register.
- fwd_hit, out, 1, a pending register write to fwd_num exists.
- fwd_val, out, DATA_W, data of the newest such pending write.
- err_illegal, out, 1, sticky flag for an illegal op encoding.
- retire_count, out, CNT_W, number of retired writebacks.

Function
REQ-004 The unit SHALL hold a FIFO of DEPTH entries, each entry being {kind (REG or CPSR), rd_num, value}, with an occupancy count from 0 to DEPTH.
REQ-005 in_ready SHALL equal (count < DEPTH) and SHALL be independent of the current cycle's pop, so there is no full-queue pass-through.
REQ-006 An accept SHALL occur when in_valid and in_ready are both high at a rising clk edge.
REQ-007 On an accept with exactly one op bit set, an entry SHALL be pushed as follows:
- ALU: kind REG, value result.
- Load: kind REG, value dmem_val.
- Compare: kind CPSR, value cpsr_in.
- rd_num is stored for every kind.
REQ-008 On an accept with no op bit set (a bubble), the instruction SHALL be consumed and no entry pushed.
REQ-009 On an accept with two or more op bits set, the instruction SHALL be consumed with no entry pushed, and err_illegal SHALL be set and held until reset.
REQ-010 Head outputs SHALL be combinational from the queue head:
- rd_write_en = (count>0) and head kind REG.
- cpsr_write_en = (count>0) and head kind CPSR.
- rd_num and rd_val SHALL come from the head entry.
- cpsr_out SHALL equal the head value whenever the head kind is CPSR.
REQ-011 When the queue is empty, rd_write_en and cpsr_write_en SHALL be 0; rd_num, rd_val and cpsr_out SHALL hold their last driven values (0 after reset).
REQ-012 A pop SHALL occur at a clk edge where count>0 and rf_ready is high; the head advances and retire_count increments, wrapping modulo 2^CNT_W.
REQ-013 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-014 Latency: an entry pushed at edge N SHALL appear at the outputs no earlier than the cycle after edge N, and exactly then if the queue was empty.
REQ-015 The read and write pointers SHALL be log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
REQ-016 Forwarding SHALL behave as follows:
- fwd_hit is 1 iff any occupied REG-kind entry has rd_num == fwd_num.
- fwd_val is the value of the youngest such entry, or 0 when there is no hit.
- CPSR entries SHALL be ignored.
- The lookup SHALL be purely combinational and SHALL exclude the instruction being accepted in the same cycle.
REQ-017 When rf_ready is low, the head SHALL be held and its outputs SHALL remain stable.

Reset
REQ-018 While reset is high, the unit SHALL asynchronously force:
- count=0 and both pointers=0.
- err_illegal=0, retire_count=0.
- rd_write_en=0, cpsr_write_en=0, rd_num=0, rd_val=0, cpsr_out=0.
- fwd_hit=0, fwd_val=0.
- in_ready=0.
REQ-019 A reset asserted mid-operation SHALL discard all pending entries without issuing any write.
REQ-020 in_ready SHALL rise in the first cycle after reset deassertion.

Verification
REQ-021 Single ALU op: push ALU op with rd 3, result 0xDEADBEEF, rf_ready=1 -> next cycle rd_write_en=1, rd_num=3, rd_val=0xDEADBEEF; the cycle after, empty and retire_count=1.
REQ-022 Compare and load ordering: push CMP with cpsr 0x80000000, then LD with rd 5, dmem 0x1234 -> cpsr_write_en=1 with cpsr_out=0x80000000 first, then rd_write_en=1 with rd_val=0x1234; retire_count=2.
REQ-023 Backpressure: hold rf_ready=0, push 4 ALU ops -> in_ready=0 after the 4th; a 5th in_valid is not accepted; release rf_ready -> 4 writes in order, with in_ready=1 again after the first pop.
REQ-024 Forwarding: queue ALU rd 7=0x11, then ALU rd 7=0x22, with rf_ready=0 and fwd_num=7 -> fwd_hit=1, fwd_val=0x22; with fwd_num=2 -> fwd_hit=0, fwd_val=0.
REQ-025 Illegal encoding and bubble: push with is_alu_op=is_ld_op=1 -> no write, err_illegal=1 held until reset; push with no op bit set -> accepted, no write, retire_count unchanged.
REQ-026 Reset mid-operation: with 3 entries queued, assert reset -> all outputs 0 immediately, and no writes after deassertion.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit
//   Buffers completed instructions in a small FIFO and drains them, one per
//   cycle, into the register file or the CPSR. It also offers a combinational
//   forwarding lookup over the pending register writes.
//
// Handshakes:
//   Upstream: an instruction is accepted on a rising clk edge where in_valid
//   and in_ready are both high. in_ready depends only on occupancy, never on
//   this cycle's pop. Downstream: the head entry is retired on a rising clk
//   edge where the queue is non-empty and rf_ready is high. While rf_ready is
//   low, the head and its outputs stay stable.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid / in_ready         upstream handshake
//   is_alu_op/is_cmp_op/is_ld_op  one-hot op class (none = bubble, >1 = illegal)
//   rd_num_in, result, cpsr_in, dmem_val  instruction payload
//   rf_ready                    register file accepts a write this cycle
//   rd_write_en/rd_num/rd_val   register write port (head entry)
//   cpsr_write_en/cpsr_out      CPSR write port (head entry)
//   fwd_num/fwd_hit/fwd_val     forwarding query over pending REG writes
//   err_illegal                 sticky illegal-encoding flag
//   retire_count                retired writebacks, wraps modulo 2^CNT_W
module writeback_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  is_alu_op,
  input  logic                  is_cmp_op,
  input  logic                  is_ld_op,
  input  logic [REG_ADDR_W-1:0] rd_num_in,
  input  logic [DATA_W-1:0]     result,
  input  logic [DATA_W-1:0]     cpsr_in,
  input  logic [DATA_W-1:0]     dmem_val,
  input  logic                  rf_ready,
  output logic                  rd_write_en,
  output logic [REG_ADDR_W-1:0] rd_num,
  output logic [DATA_W-1:0]     rd_val,
  output logic                  cpsr_write_en,
  output logic [DATA_W-1:0]     cpsr_out,
  input  logic [REG_ADDR_W-1:0] fwd_num,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_val,
  output logic                  err_illegal,
  output logic [CNT_W-1:0]      retire_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  localparam logic KIND_REG  = 1'b0;
  localparam logic KIND_CPSR = 1'b1;

  // Queue storage. Entries are only observed while occupied, so no reset.
  logic                  kind_mem [DEPTH];
  logic [REG_ADDR_W-1:0] num_mem  [DEPTH];
  logic [DATA_W-1:0]     val_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;

  // Last values driven while non-empty; shown again once the queue drains.
  logic [REG_ADDR_W-1:0] last_rd_num;
  logic [DATA_W-1:0]     last_rd_val;
  logic [DATA_W-1:0]     last_cpsr;

  logic [1:0]        n_ops;
  logic              accept;
  logic              push;
  logic              pop;
  logic              illegal;
  logic              not_empty;
  logic              push_kind;
  logic [DATA_W-1:0] push_val;
  logic              head_kind;

  assign n_ops     = {1'b0, is_alu_op} + {1'b0, is_cmp_op} + {1'b0, is_ld_op};
  assign not_empty = (count != '0);
  assign in_ready  = ~reset & (count < CW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign push      = accept & (n_ops == 2'd1);
  assign illegal   = accept & n_ops[1];
  assign pop       = not_empty & rf_ready;
  assign head_kind = kind_mem[rd_ptr];

  // Payload select; only meaningful when exactly one op bit is set.
  always_comb begin
    push_kind = KIND_REG;
    push_val  = result;
    if (is_ld_op) begin
      push_val = dmem_val;
    end
    if (is_cmp_op) begin
      push_kind = KIND_CPSR;
      push_val  = cpsr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      kind_mem[wr_ptr] <= push_kind;
      num_mem[wr_ptr]  <= rd_num_in;
      val_mem[wr_ptr]  <= push_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_illegal  <= 1'b0;
      retire_count <= '0;
      last_rd_num  <= '0;
      last_rd_val  <= '0;
      last_cpsr    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        retire_count <= retire_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (illegal) begin
        err_illegal <= 1'b1;
      end
      if (not_empty) begin
        last_rd_num <= num_mem[rd_ptr];
        last_rd_val <= val_mem[rd_ptr];
        if (head_kind == KIND_CPSR) begin
          last_cpsr <= val_mem[rd_ptr];
        end
      end
    end
  end

  assign rd_write_en   = not_empty & (head_kind == KIND_REG);
  assign cpsr_write_en = not_empty & (head_kind == KIND_CPSR);
  assign rd_num        = not_empty ? num_mem[rd_ptr] : last_rd_num;
  assign rd_val        = not_empty ? val_mem[rd_ptr] : last_rd_val;
  assign cpsr_out      = cpsr_write_en ? val_mem[rd_ptr] : last_cpsr;

  // Scan oldest to youngest so the youngest matching REG entry wins. The
  // instruction being accepted this cycle is not yet in the queue.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit = 1'b0;
    fwd_val = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CW'(i) < count) && (kind_mem[idx] == KIND_REG) &&
          (num_mem[idx] == fwd_num)) begin
        fwd_hit = 1'b1;
        fwd_val = val_mem[idx];
      end
    end
  end

endmodule
